// File: rtl/spi_shift_engine.sv
// SPI mode-0 master shift engine. Edge-detects the divided clock coming from
// the clock divider and uses the resulting ticks to generate sclk_out, cs_n
// and mosi, and to capture miso. Data is shifted MSB first.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | cs_n high, waiting for an accepted start
// SETUP | cs_n low, first bit on mosi, waiting for first fall_tick
// SHIFT | sclk_out follows divided clock; capture on rise, shift on fall
// HOLD  | last bit done, sclk_out low; release cs_n on next rise_tick
module spi_shift_engine #(
   parameter int DATA_WIDTH = 32,
   localparam int CNT_W = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  input_clock,
   input  logic                  divider_reset,
   input  logic                  spi_clk_in,
   input  logic [4:0]            clock_divider_factor,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic [CNT_W-1:0]      num_bits,
   input  logic                  miso,
   output logic                  sclk_out,
   output logic                  mosi,
   output logic                  cs_n,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_error
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  clk_q, clk_q2;
   logic                  rise_tick, fall_tick;
   logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_WIDTH-1:0] rx_data_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]      nbits_q, nbits_d;
   logic                  sclk_d, mosi_d, cs_n_d, busy_d, done_d, cfg_error_d;
   logic                  start_bad;
   logic [CNT_W-1:0]      tx_shamt;
   logic [DATA_WIDTH-1:0] tx_aligned;
   logic [DATA_WIDTH-1:0] rx_mask;

   assign rise_tick = clk_q & ~clk_q2;
   assign fall_tick = ~clk_q & clk_q2;

   // Factor 0 means the divider passes input_clock straight through, which
   // cannot be sampled into usable ticks.
   assign start_bad  = (clock_divider_factor == 5'd0) || (num_bits == '0) ||
                       (num_bits > CNT_W'(DATA_WIDTH));
   assign tx_shamt   = CNT_W'(DATA_WIDTH) - num_bits;
   assign tx_aligned = tx_data << tx_shamt;
   assign rx_mask    = {DATA_WIDTH{1'b1}} >> (CNT_W'(DATA_WIDTH) - nbits_q);

   // State and datapath registers; reset aborts any transfer without a done pulse.
   always_ff @(posedge input_clock or posedge divider_reset) begin
      if (divider_reset) begin
         state_q   <= IDLE;
         clk_q     <= 1'b0;
         clk_q2    <= 1'b0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data   <= '0;
         bit_cnt_q <= '0;
         nbits_q   <= '0;
         sclk_out  <= 1'b0;
         mosi      <= 1'b0;
         cs_n      <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_error <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_q     <= spi_clk_in;
         clk_q2    <= clk_q;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data   <= rx_data_d;
         bit_cnt_q <= bit_cnt_d;
         nbits_q   <= nbits_d;
         sclk_out  <= sclk_d;
         mosi      <= mosi_d;
         cs_n      <= cs_n_d;
         busy      <= busy_d;
         done      <= done_d;
         cfg_error <= cfg_error_d;
      end
   end

   // Next-state and next-register values; done/cfg_error default low so they pulse.
   always_comb begin
      state_d     = state_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      rx_data_d   = rx_data;
      bit_cnt_d   = bit_cnt_q;
      nbits_d     = nbits_q;
      sclk_d      = sclk_out;
      mosi_d      = mosi;
      cs_n_d      = cs_n;
      busy_d      = busy;
      done_d      = 1'b0;
      cfg_error_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            sclk_d = 1'b0;
            // The cycle done is high still counts as the end of the previous
            // transfer, so a start landing there is dropped.
            if (start && !done) begin
               if (start_bad) begin
                  cfg_error_d = 1'b1;
               end else begin
                  tx_sr_d   = tx_aligned;
                  mosi_d    = tx_aligned[DATA_WIDTH-1];
                  rx_sr_d   = '0;
                  bit_cnt_d = '0;
                  nbits_d   = num_bits;
                  cs_n_d    = 1'b0;
                  busy_d    = 1'b1;
                  state_d   = SETUP;
               end
            end
         end
         SETUP: begin
            sclk_d = 1'b0;
            if (fall_tick) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sclk_d = clk_q;
            if (rise_tick) begin
               rx_sr_d   = {rx_sr_q[DATA_WIDTH-2:0], miso};
               bit_cnt_d = bit_cnt_q + 1'b1;
            end else if (fall_tick) begin
               if (bit_cnt_q == nbits_q) begin
                  state_d = HOLD;
               end else begin
                  tx_sr_d = tx_sr_q << 1;
                  mosi_d  = tx_sr_d[DATA_WIDTH-1];
               end
            end
         end
         HOLD: begin
            sclk_d = 1'b0;
            if (rise_tick) begin
               cs_n_d    = 1'b1;
               mosi_d    = 1'b0;
               rx_data_d = rx_sr_q & rx_mask;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine with a behavioural clock divider model.
module tb_spi_shift_engine;

   logic        input_clock = 1'b0;
   logic        divider_reset;
   logic        spi_clk_in;
   logic [4:0]  clock_divider_factor;
   logic        start;
   logic [31:0] tx_data;
   logic [5:0]  num_bits;
   logic        miso;
   logic        sclk_out, mosi, cs_n, busy, done, cfg_error;
   logic [31:0] rx_data;

   logic [31:0] div_cnt;
   int          total = 0;
   int          bad = 0;

   // monitor state
   logic        sclk_prev = 1'b0;
   int          rise_cnt = 0;
   int          done_cyc = 0;
   int          cfg_cyc = 0;
   int          cs_low = 0;
   int          ovl_cnt = 0;
   int          idle_sclk = 0;
   logic [63:0] mosi_log = '0;

   // miso source
   bit          loop_en = 1'b1;
   logic [31:0] pat_word = '0;
   int          pat_len = 0;
   int          rise_base = 0;
   int          pidx;

   spi_shift_engine #(.DATA_WIDTH(32)) dut (
      .input_clock          (input_clock),
      .divider_reset        (divider_reset),
      .spi_clk_in           (spi_clk_in),
      .clock_divider_factor (clock_divider_factor),
      .start                (start),
      .tx_data              (tx_data),
      .num_bits             (num_bits),
      .miso                 (miso),
      .sclk_out             (sclk_out),
      .mosi                 (mosi),
      .cs_n                 (cs_n),
      .rx_data              (rx_data),
      .busy                 (busy),
      .done                 (done),
      .cfg_error            (cfg_error)
   );

   always #5 input_clock = ~input_clock;

   // divider model: P = 2^factor, factor 0 passes the clock through
   always @(posedge input_clock or posedge divider_reset) begin
      if (divider_reset) div_cnt <= '0;
      else               div_cnt <= div_cnt + 32'd1;
   end
   assign spi_clk_in = (clock_divider_factor == 5'd0) ? input_clock
                                                       : div_cnt[clock_divider_factor - 5'd1];

   // miso either loops mosi back or plays a pattern, one bit per sclk rise
   always_comb begin
      pidx = pat_len - 1 - (rise_cnt - rise_base);
      if (loop_en)                    miso = mosi;
      else if (pidx >= 0 && pidx < 32) miso = pat_word[pidx];
      else                            miso = 1'b0;
   end

   // output monitor, sampled on the falling edge
   always @(negedge input_clock) begin
      sclk_prev <= sclk_out;
      if (sclk_out && !sclk_prev) begin
         rise_cnt <= rise_cnt + 1;
         mosi_log <= {mosi_log[62:0], mosi};
      end
      if (done)                          done_cyc  <= done_cyc + 1;
      if (cfg_error)                     cfg_cyc   <= cfg_cyc + 1;
      if (!cs_n)                         cs_low    <= cs_low + 1;
      if (done && (cfg_error || busy))   ovl_cnt   <= ovl_cnt + 1;
      if (sclk_out && cs_n)              idle_sclk <= idle_sclk + 1;
   end

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset(input logic [4:0] f);
      @(negedge input_clock);
      divider_reset = 1'b1;
      clock_divider_factor = f;
      start = 1'b0;
      repeat (3) @(negedge input_clock);
      divider_reset = 1'b0;
      repeat (3) @(negedge input_clock);
   endtask

   task automatic pulse_start(input logic [31:0] tx, input logic [5:0] n);
      @(negedge input_clock);
      start = 1'b1;
      tx_data = tx;
      num_bits = n;
      @(negedge input_clock);
      start = 1'b0;
      tx_data = 32'h0;
      num_bits = 6'd0;
   endtask

   task automatic run_xfer(input string tag, input bit rst, input logic [4:0] f,
                           input logic [5:0] n, input logic [31:0] tx, input bit loop,
                           input logic [31:0] pat, input logic [31:0] exp_rx,
                           input bit extra_start, input int cs_lo, input int cs_hi);
      int b_rise, b_done, b_cfg, b_cs, b_ovl, b_idle, cyc, p;
      bit found;
      logic [31:0] m;
      if (rst) do_reset(f);
      p = 1 << f;
      m = (n == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
      loop_en = loop;
      pat_word = pat;
      pat_len = int'(n);
      @(negedge input_clock);
      b_rise = rise_cnt; b_done = done_cyc; b_cfg = cfg_cyc;
      b_cs = cs_low; b_ovl = ovl_cnt; b_idle = idle_sclk;
      rise_base = rise_cnt;
      pulse_start(tx, n);
      cyc = 1;
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (done) begin
            found = 1'b1;
            break;
         end
         if (extra_start && i == 12) begin
            start = 1'b1; tx_data = ~tx; num_bits = 6'd8;
         end else begin
            start = 1'b0;
         end
         @(negedge input_clock);
         cyc++;
      end
      start = 1'b0;
      chk_val({tag, "_done_seen"}, found, 1'b1);
      chk_val({tag, "_latency_ok"}, cyc <= (int'(n) + 3) * p + 3, 1'b1);
      repeat (4) @(negedge input_clock);
      chk_val({tag, "_rx_data"}, rx_data, exp_rx);
      chk_val({tag, "_sclk_rises"}, rise_cnt - b_rise, n);
      chk_val({tag, "_done_cycles"}, done_cyc - b_done, 1);
      chk_val({tag, "_no_cfg_error"}, cfg_cyc - b_cfg, 0);
      chk_val({tag, "_no_overlap"}, ovl_cnt - b_ovl, 0);
      chk_val({tag, "_no_idle_sclk"}, idle_sclk - b_idle, 0);
      chk_val({tag, "_end_cs_n"}, cs_n, 1'b1);
      chk_val({tag, "_end_busy"}, busy, 1'b0);
      chk_val({tag, "_cs_low_ok"}, (cs_low - b_cs >= cs_lo) && (cs_low - b_cs <= cs_hi), 1'b1);
      if (loop) chk_val({tag, "_mosi_bits"}, mosi_log[31:0] & m, tx & m);
   endtask

   task automatic try_reject(input string tag, input logic [4:0] f, input logic [5:0] n);
      int b_cfg;
      do_reset(f);
      b_cfg = cfg_cyc;
      @(negedge input_clock);
      start = 1'b1; tx_data = 32'h5A; num_bits = n;
      @(negedge input_clock);
      start = 1'b0;
      chk_val({tag, "_cfg_pulse"}, cfg_error, 1'b1);
      chk_val({tag, "_cs_n"}, cs_n, 1'b1);
      @(negedge input_clock);
      chk_val({tag, "_cfg_clear"}, cfg_error, 1'b0);
      repeat (10) @(negedge input_clock);
      chk_val({tag, "_busy"}, busy, 1'b0);
      chk_val({tag, "_cs_n_later"}, cs_n, 1'b1);
      chk_val({tag, "_cfg_count"}, cfg_cyc - b_cfg, 1);
   endtask

   initial begin
      int b_done, seen;
      bit hit;
      logic prev;
      divider_reset = 1'b1;
      clock_divider_factor = 5'd2;
      start = 1'b0;
      tx_data = 32'h0;
      num_bits = 6'd0;
      repeat (3) @(negedge input_clock);
      chk_val("reset_cs_n", cs_n, 1'b1);
      chk_val("reset_sclk", sclk_out, 1'b0);
      chk_val("reset_mosi", mosi, 1'b0);
      chk_val("reset_busy", busy, 1'b0);
      chk_val("reset_done", done, 1'b0);
      chk_val("reset_cfg_error", cfg_error, 1'b0);
      chk_val("reset_rx_data", rx_data, 32'h0);

      run_xfer("basic", 1'b1, 5'd2, 6'd8, 32'h0000_00A5, 1'b1, 32'h0, 32'h0000_00A5, 1'b0, 34, 40);
      run_xfer("full", 1'b1, 5'd1, 6'd32, 32'hDEAD_BEEF, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, 64, 69);
      try_reject("rej_f0", 5'd0, 6'd8);
      try_reject("rej_n0", 5'd3, 6'd0);
      try_reject("rej_n33", 5'd3, 6'd33);
      run_xfer("busy_start", 1'b1, 5'd3, 6'd4, 32'h0000_0009, 1'b1, 32'h0, 32'h0000_0009, 1'b1, 36, 46);
      run_xfer("miso_pat", 1'b1, 5'd2, 6'd5, 32'h0000_0000, 1'b0, 32'h0000_0019, 32'h0000_0019, 1'b0, 22, 28);

      // reset abort after the 3rd sclk rise
      do_reset(5'd2);
      loop_en = 1'b1;
      b_done = done_cyc;
      pulse_start(32'h0000_00A5, 6'd8);
      seen = 0;
      hit = 1'b0;
      prev = sclk_out;
      for (int i = 0; i < 400; i++) begin
         @(negedge input_clock);
         if (sclk_out && !prev) seen++;
         prev = sclk_out;
         if (seen == 3) begin
            hit = 1'b1;
            break;
         end
      end
      chk_val("abort_third_rise_seen", hit, 1'b1);
      divider_reset = 1'b1;
      #1;
      chk_val("abort_cs_n", cs_n, 1'b1);
      chk_val("abort_sclk", sclk_out, 1'b0);
      chk_val("abort_busy", busy, 1'b0);
      chk_val("abort_rx_data", rx_data, 32'h0);
      repeat (2) @(negedge input_clock);
      divider_reset = 1'b0;
      repeat (60) @(negedge input_clock);
      chk_val("abort_no_done", done_cyc - b_done, 0);
      run_xfer("after_abort", 1'b0, 5'd2, 6'd8, 32'h0000_003C, 1'b1, 32'h0, 32'h0000_003C, 1'b0, 34, 40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
